// File: rtl/gold_nic_if.sv
// ---------------------------------------------------------------------------
// gold_nic_if
// Bundles the gold_nic processor load/store port and its link to the PE port
// of gold_router.
//
// Processor side:
//   addr     register select (000 RX data, 001 RX status, 010 TX data,
//            011 TX status, 100 counters)
//   d_in     write data
//   d_out    read data (combinational)
//   nicEn    access enable
//   nicWrEn  1 = write, 0 = read
// Router side:
//   net_polarity  router polarity; the router's external VC is ~net_polarity
//   net_so/net_ro/net_do  injection (to router pesi/peri/pedi)
//   net_si/net_ri/net_di  ejection  (from router peso/pero/pedo)
//
// Modports: slave = the NIC, master = processor plus router environment.
// ---------------------------------------------------------------------------
interface gold_nic_if #(
    parameter int unsigned DATA_W = 64
);
    logic [2:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nicEn;
    logic              nicWrEn;

    logic              net_polarity;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;
    logic              net_si;
    logic              net_ri;
    logic [DATA_W-1:0] net_di;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_polarity, net_ro, net_si, net_di,
        output d_out, net_so, net_do, net_ri
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_polarity, net_ro, net_si, net_di,
        input  d_out, net_so, net_do, net_ri
    );
endinterface

// File: rtl/gold_nic.sv
// ---------------------------------------------------------------------------
// gold_nic
// Processor-side network interface for the PE port of gold_router. One
// outgoing packet is held in a TX buffer and offered to the router only in
// the polarity phase whose external VC matches the packet's VC bit (MSB).
// One incoming packet is held in an RX buffer until the processor reads it.
//
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous, active-low
//   bus    gold_nic_if.slave (processor load/store port + router PE link)
//
// Parameters:
//   DATA_W packet width (MSB is the VC bit)
//   CNT_W  width of each packet counter
//
// Optional feature macro GOLD_NIC_CNT_EN: adds wrapping tx/rx packet
// counters readable at address 100 as {rx_cnt, tx_cnt}; a write to 100
// clears both. Without it, address 100 reads 0 and holds no flops.
// ---------------------------------------------------------------------------
module gold_nic #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 32
) (
    input  logic      clk,
    input  logic      reset,
    gold_nic_if.slave bus
);

    typedef enum logic [2:0] {
        A_RX_DATA = 3'b000,
        A_RX_STAT = 3'b001,
        A_TX_DATA = 3'b010,
        A_TX_STAT = 3'b011,
        A_CNT     = 3'b100
    } addr_e;

    logic              r_live;
    logic              r_rx_full;
    logic              r_tx_full;
    logic [DATA_W-1:0] r_rx_buf;
    logic [DATA_W-1:0] r_tx_buf;

    logic              w_rd;
    logic              w_wr;
    logic              w_vc_match;
    logic              w_net_so;
    logic              w_net_ri;
    logic              w_rx_take;
    logic              w_rx_pop;
    logic              w_tx_load;
    logic              w_tx_xfer;
    logic [2*CNT_W-1:0] w_cnt_cat;
    logic [DATA_W-1:0] w_d_out;

    assign w_rd = bus.nicEn & ~bus.nicWrEn;
    assign w_wr = bus.nicEn &  bus.nicWrEn;

    // A packet is offered only while the router's external VC (~polarity)
    // equals the packet's own VC bit; otherwise it waits for the next phase.
    assign w_vc_match = (r_tx_buf[DATA_W-1] == ~bus.net_polarity);
    assign w_net_so   = r_tx_full & w_vc_match;

    // r_live keeps net_ri low during reset and lifts it on the first clock
    // after release.
    assign w_net_ri   = r_live & ~r_rx_full;

    assign w_rx_take  = bus.net_si & w_net_ri;
    assign w_rx_pop   = w_rd & (bus.addr == A_RX_DATA);
    assign w_tx_load  = w_wr & (bus.addr == A_TX_DATA) & ~r_tx_full;
    assign w_tx_xfer  = w_net_so & bus.net_ro;

    assign bus.net_so = w_net_so;
    assign bus.net_do = w_net_so ? r_tx_buf : '0;
    assign bus.net_ri = w_net_ri;
    assign bus.d_out  = w_d_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live    <= 1'b0;
            r_rx_full <= 1'b0;
            r_rx_buf  <= '0;
            r_tx_full <= 1'b0;
            r_tx_buf  <= '0;
        end else begin
            r_live <= 1'b1;

            // Take and pop cannot collide: take needs empty, pop only
            // changes state when full.
            if (w_rx_take) begin
                r_rx_buf  <= bus.net_di;
                r_rx_full <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_full <= 1'b0;
            end

            // Load needs empty, transfer needs full: mutually exclusive, so
            // a write in the transfer cycle is dropped.
            if (w_tx_load) begin
                r_tx_buf  <= bus.d_in;
                r_tx_full <= 1'b1;
            end else if (w_tx_xfer) begin
                r_tx_full <= 1'b0;
            end
        end
    end

`ifdef GOLD_NIC_CNT_EN
    logic [CNT_W-1:0] r_tx_cnt;
    logic [CNT_W-1:0] r_rx_cnt;
    logic             w_cnt_clr;

    assign w_cnt_clr = w_wr & (bus.addr == A_CNT);

    // Clear wins over a coincident increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_xfer) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            if (w_rx_take) r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        end
    end

    assign w_cnt_cat = {r_rx_cnt, r_tx_cnt};
`else
    assign w_cnt_cat = '0;
`endif

    always_comb begin
        w_d_out = '0;
        if (w_rd) begin
            case (bus.addr)
                A_RX_DATA: w_d_out = r_rx_buf;
                A_RX_STAT: w_d_out = {{(DATA_W-1){1'b0}}, r_rx_full};
                A_TX_STAT: w_d_out = {{(DATA_W-1){1'b0}}, r_tx_full};
                A_CNT:     w_d_out = DATA_W'(w_cnt_cat);
                default:   w_d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// ---------------------------------------------------------------------------
// tb_gold_nic
// Directed bench for gold_nic: reset state, TX injection with polarity
// gating and backpressure, RX ejection with bubble, counters, and reset in
// the middle of a pending injection.
// ---------------------------------------------------------------------------
module tb_gold_nic;

    localparam int unsigned DW = 64;

    localparam logic [63:0] PKT_A001 = 64'h0003_0000_0000_A001;
    localparam logic [63:0] PKT_A002 = 64'h0003_0000_0000_A002;
    localparam logic [63:0] PKT_A003 = 64'h0003_0000_0000_A003;
    localparam logic [63:0] PKT_B001 = 64'h8003_0000_0000_B001;
    localparam logic [63:0] PKT_C001 = 64'h8003_0000_0000_C001;
    localparam logic [63:0] PKT_EE00 = 64'h0000_0000_0000_EE00;
    localparam logic [63:0] PKT_EE01 = 64'h0000_0000_0000_EE01;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    gold_nic_if #(.DATA_W(DW)) bus ();

    gold_nic #(.DATA_W(DW), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        bus.addr    = a;
        bus.d_in    = d;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b1;
        cyc();
        bus.nicEn   = 1'b0;
        bus.nicWrEn = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [63:0] exp);
        bus.addr    = a;
        bus.nicEn   = 1'b1;
        bus.nicWrEn = 1'b0;
        #1;
        check(tag, bus.d_out, exp);
        cyc();
        bus.nicEn   = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        bus.addr = 3'b000;
        bus.d_in = '0;
        bus.nicEn = 1'b0;
        bus.nicWrEn = 1'b0;
        bus.net_polarity = 1'b0;
        bus.net_ro = 1'b0;
        bus.net_si = 1'b0;
        bus.net_di = '0;

        // 1: reset
        repeat (5) cyc();
        bus.nicEn = 1'b1;
        #1;
        check("rst_so", {63'b0, bus.net_so}, 64'd0);
        check("rst_do", bus.net_do, 64'd0);
        check("rst_dout", bus.d_out, 64'd0);
        check("rst_ri", {63'b0, bus.net_ri}, 64'd0);
        bus.nicEn = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        check("post_rst_ri", {63'b0, bus.net_ri}, 64'd1);
        rd("post_rst_rxst", 3'b001, 64'd0);
        rd("post_rst_txst", 3'b011, 64'd0);

        // 2: TX VC0 packet gated by polarity
        bus.net_ro = 1'b1;
        bus.net_polarity = 1'b0;
        wr(3'b010, PKT_A001);
        check("tx_gate_so", {63'b0, bus.net_so}, 64'd0);
        check("tx_gate_do", bus.net_do, 64'd0);
        rd("tx_gate_st", 3'b011, 64'd1);
        bus.net_polarity = 1'b1;
        #1;
        check("tx_match_so", {63'b0, bus.net_so}, 64'd1);
        check("tx_match_do", bus.net_do, PKT_A001);
        cyc();
        check("tx_done_so", {63'b0, bus.net_so}, 64'd0);
        check("tx_done_do", bus.net_do, 64'd0);
        rd("tx_done_st", 3'b011, 64'd0);

        // 3: backpressure, second write dropped
        bus.net_ro = 1'b0;
        wr(3'b010, PKT_A001);
        for (int i = 0; i < 5; i++) begin
            check("bp_so", {63'b0, bus.net_so}, 64'd1);
            check("bp_do", bus.net_do, PKT_A001);
            if (i == 2) wr(3'b010, PKT_A002);
            else cyc();
        end
        rd("bp_st", 3'b011, 64'd1);
        bus.net_ro = 1'b1;
        #1;
        check("bp_rel_do", bus.net_do, PKT_A001);
        cyc();
        bus.net_ro = 1'b0;
        check("bp_after_so", {63'b0, bus.net_so}, 64'd0);
        rd("bp_after_st", 3'b011, 64'd0);
        check("bp_no_a002", {63'b0, bus.net_so}, 64'd0);

        // VC1 packet with polarity 0; write during the transfer cycle is dropped
        bus.net_polarity = 1'b0;
        wr(3'b010, PKT_B001);
        check("vc1_so", {63'b0, bus.net_so}, 64'd1);
        check("vc1_do", bus.net_do, PKT_B001);
        bus.net_ro = 1'b1;
        bus.addr = 3'b010;
        bus.d_in = PKT_C001;
        bus.nicEn = 1'b1;
        bus.nicWrEn = 1'b1;
        cyc();
        bus.nicEn = 1'b0;
        bus.nicWrEn = 1'b0;
        bus.net_ro = 1'b0;
        check("xfer_wr_so", {63'b0, bus.net_so}, 64'd0);
        rd("xfer_wr_st", 3'b011, 64'd0);

        // 4: RX with one-cycle bubble
        bus.net_si = 1'b1;
        bus.net_di = PKT_EE00;
        cyc();
        bus.net_di = PKT_EE01;
        check("rx_ri_low", {63'b0, bus.net_ri}, 64'd0);
        rd("rx_st_full", 3'b001, 64'd1);
        check("rx_ri_held", {63'b0, bus.net_ri}, 64'd0);
        rd("rx_data", 3'b000, PKT_EE00);
        check("rx_ri_back", {63'b0, bus.net_ri}, 64'd1);
        cyc();
        bus.net_si = 1'b0;
        check("rx2_ri_low", {63'b0, bus.net_ri}, 64'd0);
        bus.addr = 3'b000;
        bus.nicEn = 1'b1;
        bus.nicWrEn = 1'b1;
        #1;
        check("wr_dout_zero", bus.d_out, 64'd0);
        bus.nicEn = 1'b0;
        bus.nicWrEn = 1'b0;
        #1;
        check("dis_dout_zero", bus.d_out, 64'd0);
        rd("rx2_data", 3'b000, PKT_EE01);
        rd("rx_stale", 3'b000, PKT_EE01);
        rd("rx_st_empty", 3'b001, 64'd0);

        // 6: counters (3 TX, 2 RX so far)
`ifdef GOLD_NIC_CNT_EN
        rd("cnt_read", 3'b100, 64'h0000_0002_0000_0003);
`else
        rd("cnt_read", 3'b100, 64'd0);
`endif
        wr(3'b100, 64'hDEAD_BEEF_0000_0001);
        rd("cnt_clr", 3'b100, 64'd0);

        // 5: reset with a pending, back-pressured packet
        bus.net_polarity = 1'b1;
        bus.net_ro = 1'b0;
        wr(3'b010, PKT_A003);
        check("mid_so_before", {63'b0, bus.net_so}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_so_async", {63'b0, bus.net_so}, 64'd0);
        check("mid_do_async", bus.net_do, 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        rd("mid_txst", 3'b011, 64'd0);
        check("mid_so_after", {63'b0, bus.net_so}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
